// File: rtl/sad_column_window.sv
// sad_column_window
// Column-SAD engine. Each accepted NDATA_IN-bit difference column is
// popcounted by a registered binary adder tree (LVL levels after an input
// register), then folded into a running sum over the newest WIN columns of
// the current frame.
//
// Handshake: din_valid is a one-way valid with no ready. Every cycle with
// din_valid high is consumed, and frame_start is only meaningful in those
// cycles. col_valid and dout_valid are single-cycle pulses, one per column.
// In cycles without a valid column, col_count and dout hold their last
// values.
//
// Optional feature macro: SADWIN_MIN_TRACK_EN. When it is defined, the
// smallest full-window SAD of the frame and its column index are tracked.
// When it is undefined, min_sad and min_idx are tied to zero.
module sad_column_window #(
    parameter int NDATA_IN = 100,
    parameter int WIN      = 8,
    parameter int IDXW     = 16,
    localparam int LVL     = $clog2(NDATA_IN),
    localparam int CW      = $clog2(NDATA_IN + 1),
    localparam int SW      = $clog2(NDATA_IN * WIN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic [NDATA_IN-1:0] din,
    input  logic                frame_start,
    output logic                col_valid,
    output logic [CW-1:0]       col_count,
    output logic                dout_valid,
    output logic [SW-1:0]       dout,
    output logic [SW-1:0]       min_sad,
    output logic [IDXW-1:0]     min_idx
);

    localparam int NPAD = 2 ** LVL;
    localparam int PW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int FW   = $clog2(WIN + 1);

    // ------------------------------------------------------------------
    // Level 0: input register, zero-padded to a power of two.
    // ------------------------------------------------------------------
    logic [NPAD-1:0] pad_d, pad_q;
    logic [LVL:0]    vld_d, vld_q;
    logic [LVL:0]    fs_d, fs_q;

    // Capture a valid column; hold the register across bubbles.
    always_comb begin
        pad_d = pad_q;
        if (din_valid) begin
            pad_d = NPAD'(din);
        end
    end

    // Valid and frame_start flags ride alongside each tree level.
    always_comb begin
        vld_d = {vld_q[LVL-1:0], din_valid};
        fs_d  = {fs_q[LVL-1:0], din_valid & frame_start};
    end

    // Input register and the sideband pipes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= '0;
            vld_q <= '0;
            fs_q  <= '0;
        end else begin
            pad_q <= pad_d;
            vld_q <= vld_d;
            fs_q  <= fs_d;
        end
    end

    // ------------------------------------------------------------------
    // Adder tree: level k sums pairs of level k-1. Each level only loads
    // when the column below it is valid, so the final count holds over
    // bubbles. The last level is narrowed to CW bits, which is lossless
    // because the count cannot exceed NDATA_IN.
    // ------------------------------------------------------------------
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int N = 2 ** (LVL - k);
        localparam int W = (k == LVL) ? CW : k + 1;
        logic [W-1:0] node_d [N];
        logic [W-1:0] node_q [N];

        if (k == 1) begin : g_first
            // Pair up the padded input bits.
            always_comb begin
                node_d = node_q;
                if (vld_q[0]) begin
                    for (int i = 0; i < N; i++) begin
                        node_d[i] = W'(pad_q[2*i]) + W'(pad_q[2*i+1]);
                    end
                end
            end
        end else begin : g_rest
            // Pair up the partial sums of the level below.
            always_comb begin
                node_d = node_q;
                if (vld_q[k-1]) begin
                    for (int i = 0; i < N; i++) begin
                        node_d[i] = W'(g_lvl[k-1].node_q[2*i]) + W'(g_lvl[k-1].node_q[2*i+1]);
                    end
                end
            end
        end

        // Tree level register.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    node_q[i] <= '0;
                end
            end else begin
                node_q <= node_d;
            end
        end
    end

    logic col_fs;

    assign col_count = g_lvl[LVL].node_q[0];
    assign col_valid = vld_q[LVL];
    assign col_fs    = fs_q[LVL];

    // ------------------------------------------------------------------
    // Window stage: circular buffer of the last WIN column counts and a
    // running sum. A frame_start column wipes the buffer, so unfilled
    // slots subtract zero while the window is filling.
    // ------------------------------------------------------------------
    logic [CW-1:0] win_buf_d [WIN];
    logic [CW-1:0] win_buf_q [WIN];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [SW-1:0] sum_d, sum_q;
    logic [FW-1:0] fill_d, fill_q;
    logic [SW-1:0] dout_d, dout_q;
    logic          dout_valid_d, dout_valid_q;

    // Next window state for an emerging column.
    always_comb begin
        win_buf_d    = win_buf_q;
        wr_ptr_d     = wr_ptr_q;
        sum_d        = sum_q;
        fill_d       = fill_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (col_valid) begin
            if (col_fs) begin
                for (int i = 0; i < WIN; i++) begin
                    win_buf_d[i] = '0;
                end
                win_buf_d[0] = col_count;
                wr_ptr_d     = PW'(1 % WIN);
                sum_d        = SW'(col_count);
                fill_d       = FW'(1);
            end else begin
                sum_d               = sum_q + SW'(col_count) - SW'(win_buf_q[wr_ptr_q]);
                win_buf_d[wr_ptr_q] = col_count;
                wr_ptr_d            = (wr_ptr_q == PW'(WIN - 1)) ? '0 : wr_ptr_q + 1'b1;
                fill_d              = (fill_q == FW'(WIN)) ? fill_q : fill_q + 1'b1;
            end
            dout_d       = sum_d;
            dout_valid_d = (fill_d == FW'(WIN));
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) begin
                win_buf_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            win_buf_q    <= win_buf_d;
            wr_ptr_q     <= wr_ptr_d;
            sum_q        <= sum_d;
            fill_q       <= fill_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`ifdef SADWIN_MIN_TRACK_EN
    // ------------------------------------------------------------------
    // Minimum tracking. col_idx only feeds min_idx, so it lives here.
    // The compare uses the registered window result, so a new minimum
    // shows up one cycle after its dout_valid. A frame_start column
    // re-arms the tracker before any window of the new frame is compared.
    // ------------------------------------------------------------------
    logic [IDXW-1:0] col_idx_d, col_idx_q;
    logic [SW-1:0]   min_sad_d, min_sad_q;
    logic [IDXW-1:0] min_idx_d, min_idx_q;

    // Column index within the frame; wraps naturally at 2^IDXW.
    always_comb begin
        col_idx_d = col_idx_q;
        if (col_valid) begin
            col_idx_d = col_fs ? '0 : col_idx_q + 1'b1;
        end
    end

    // Strict less-than keeps the earliest of equal windows.
    always_comb begin
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        if (col_valid && col_fs) begin
            min_sad_d = '1;
            min_idx_d = '0;
        end else if (dout_valid_q && (dout_q < min_sad_q)) begin
            min_sad_d = dout_q;
            min_idx_d = col_idx_q;
        end
    end

    // Tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_idx_q <= '0;
            min_sad_q <= '1;
            min_idx_q <= '0;
        end else begin
            col_idx_q <= col_idx_d;
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
        end
    end

    assign min_sad = min_sad_q;
    assign min_idx = min_idx_q;
`else
    assign min_sad = '0;
    assign min_idx = '0;
`endif

endmodule

// File: tb/tb_sad_column_window.sv
// tb_sad_column_window
// Directed bench for sad_column_window with default parameters
// (NDATA_IN=100, WIN=8, LVL=7, LAT=8). Every column sent pushes its
// expected count and window result, tagged with the cycle it must appear.
// A negedge monitor checks each cycle: the expected pulse and value when
// due, otherwise no pulse and held outputs.
module tb_sad_column_window;

    localparam int NDATA_IN = 100;
    localparam int WIN      = 8;
    localparam int IDXW     = 16;
    localparam int CW       = $clog2(NDATA_IN + 1);
    localparam int SW       = $clog2(NDATA_IN * WIN + 1);
    localparam int LVL      = $clog2(NDATA_IN);
    localparam int SAD_ONES = (1 << SW) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                din_valid = 1'b0;
    logic [NDATA_IN-1:0] din = '0;
    logic                frame_start = 1'b0;
    logic                col_valid;
    logic [CW-1:0]       col_count;
    logic                dout_valid;
    logic [SW-1:0]       dout;
    logic [SW-1:0]       min_sad;
    logic [IDXW-1:0]     min_idx;

    sad_column_window #(
        .NDATA_IN(NDATA_IN),
        .WIN     (WIN),
        .IDXW    (IDXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .frame_start(frame_start),
        .col_valid  (col_valid),
        .col_count  (col_count),
        .dout_valid (dout_valid),
        .dout       (dout),
        .min_sad    (min_sad),
        .min_idx    (min_idx)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed vectors.
    int t1_dout [10] = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800};
    int t3_dout [12] = '{1, 3, 6, 10, 15, 21, 28, 36, 44, 52, 60, 68};
    int t4_cnt  [17] = '{5, 5, 5, 5, 5, 5, 5, 5, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    int t4_dout [17] = '{5, 10, 15, 20, 25, 30, 35, 40, 3, 6, 9, 12, 15, 18, 21, 24, 24};
    int t4_dv   [17] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int t6_cnt  [11] = '{12, 4, 4, 4, 4, 4, 4, 4, 2, 4, 24};
    int t6_dout [11] = '{12, 16, 20, 24, 28, 32, 36, 40, 30, 30, 50};

    // Scoreboard state.
    logic [CW-1:0] exp_col_q [$];
    int            exp_col_cyc_q [$];
    logic [SW-1:0] exp_dout_q [$];
    logic [0:0]    exp_dv_q [$];
    int            exp_dout_cyc_q [$];
    logic [CW-1:0] last_col = '0;
    logic [SW-1:0] last_dout = '0;
    logic          mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [NDATA_IN-1:0] ones(input int n);
        logic [NDATA_IN-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [NDATA_IN-1:0] one_bit(input int pos);
        logic [NDATA_IN-1:0] r;
        r = '0;
        r[pos] = 1'b1;
        return r;
    endfunction

    function automatic logic [NDATA_IN-1:0] rand_bits();
        logic [127:0] t;
        for (int i = 0; i < 4; i++) t[32*i +: 32] = $urandom();
        return t[NDATA_IN-1:0];
    endfunction

    // Drive one cycle of inputs; returns 1 time unit after the edge.
    task automatic drive(input logic v, input logic [NDATA_IN-1:0] d, input logic fs);
        din_valid   = v;
        din         = d;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    // Send a valid column with its expected count and window result.
    task automatic send_col(input logic [NDATA_IN-1:0] d, input logic fs,
                            input int ecnt, input int edout, input logic edv);
        int n;
        n = cyc + 1;
        exp_col_q.push_back(CW'(ecnt));
        exp_col_cyc_q.push_back(n + LVL);
        exp_dout_q.push_back(SW'(edout));
        exp_dv_q.push_back(edv);
        exp_dout_cyc_q.push_back(n + LVL + 1);
        drive(1'b1, d, fs);
    endtask

    // Bubbles carry garbage data and a stray frame_start.
    task automatic idle(input int n);
        repeat (n) drive(1'b0, rand_bits(), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        idle(LVL + 4);
        check_eq("col_q_drained", 32'(exp_col_q.size()), 32'd0);
        check_eq("dout_q_drained", 32'(exp_dout_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        rst         = 1'b1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        exp_col_q.delete();
        exp_col_cyc_q.delete();
        exp_dout_q.delete();
        exp_dv_q.delete();
        exp_dout_cyc_q.delete();
        last_col  = '0;
        last_dout = '0;
        check_eq("rst_col_valid", 32'(col_valid), 32'd0);
        check_eq("rst_col_count", 32'(col_count), 32'd0);
        check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
`ifdef SADWIN_MIN_TRACK_EN
        check_eq("rst_min_sad", 32'(min_sad), 32'(SAD_ONES));
`else
        check_eq("rst_min_sad", 32'(min_sad), 32'd0);
`endif
        check_eq("rst_min_idx", 32'(min_idx), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Per-cycle monitor, sampling away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_col_cyc_q.size() != 0 && exp_col_cyc_q[0] == cyc) begin
                check_eq("col_valid", 32'(col_valid), 32'd1);
                check_eq("col_count", 32'(col_count), 32'(exp_col_q[0]));
                last_col = exp_col_q.pop_front();
                void'(exp_col_cyc_q.pop_front());
            end else begin
                check_eq("col_valid_quiet", 32'(col_valid), 32'd0);
                check_eq("col_count_hold", 32'(col_count), 32'(last_col));
            end
            if (exp_dout_cyc_q.size() != 0 && exp_dout_cyc_q[0] == cyc) begin
                check_eq("dout_valid", 32'(dout_valid), 32'(exp_dv_q[0]));
                check_eq("dout", 32'(dout), 32'(exp_dout_q[0]));
                last_dout = exp_dout_q.pop_front();
                void'(exp_dv_q.pop_front());
                void'(exp_dout_cyc_q.pop_front());
            end else begin
                check_eq("dout_valid_quiet", 32'(dout_valid), 32'd0);
                check_eq("dout_hold", 32'(dout), 32'(last_dout));
            end
`ifndef SADWIN_MIN_TRACK_EN
            check_eq("min_sad_tied", 32'(min_sad), 32'd0);
            check_eq("min_idx_tied", 32'(min_idx), 32'd0);
`endif
        end
    end

    // Stimulus.
    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Ten all-ones columns: count 100, window full on the 8th column.
        for (int i = 0; i < 10; i++) begin
            send_col(ones(NDATA_IN), 1'(i == 0), 100, t1_dout[i], 1'(i >= 7));
        end
        drain();

        // Tree ends and padding: bit 0, bit 99, then an empty column.
        send_col(one_bit(0), 1'b1, 1, 1, 1'b0);
        send_col(one_bit(NDATA_IN - 1), 1'b0, 1, 2, 1'b0);
        send_col('0, 1'b0, 0, 2, 1'b0);
        drain();

        // Counts 1..12 with random bubbles between columns.
        for (int i = 0; i < 12; i++) begin
            send_col(ones(i + 1), 1'(i == 0), i + 1, t3_dout[i], 1'(i >= 7));
            idle($urandom_range(0, 3));
        end
        drain();

        // New frame on column 9 of a running stream.
        for (int i = 0; i < 17; i++) begin
            send_col(ones(t4_cnt[i]), 1'(i == 0 || i == 8), t4_cnt[i], t4_dout[i], 1'(t4_dv[i]));
        end
        drain();

        // Reset with five columns still in the tree.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ones(50), 1'(i == 0));
        end
        do_reset();
        drain();

`ifdef SADWIN_MIN_TRACK_EN
        // Window sums 40, 30, 30, 50 at column indices 7..10.
        for (int i = 0; i < 11; i++) begin
            send_col(ones(t6_cnt[i]), 1'(i == 0), t6_cnt[i], t6_dout[i], 1'(i >= 7));
        end
        drain();
        check_eq("min_sad_first_tie", 32'(min_sad), 32'd30);
        check_eq("min_idx_first_tie", 32'(min_idx), 32'd8);

        // New frame: tracker re-armed until its first full window.
        for (int i = 0; i < 4; i++) begin
            send_col(ones(7), 1'(i == 0), 7, 7 * (i + 1), 1'b0);
        end
        drain();
        check_eq("min_sad_rearmed", 32'(min_sad), 32'(SAD_ONES));
        check_eq("min_idx_rearmed", 32'(min_idx), 32'd0);
        for (int i = 4; i < 8; i++) begin
            send_col(ones(7), 1'b0, 7, 7 * (i + 1), 1'(i == 7));
        end
        drain();
        check_eq("min_sad_new_frame", 32'(min_sad), 32'd56);
        check_eq("min_idx_new_frame", 32'(min_idx), 32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sad_column_window.md
# sad_column_window

Pipelined, parametrised column-SAD engine: counts set bits of one NDATA_IN-bit difference column per cycle through a registered binary adder tree, then keeps a running sum over the last WIN columns of the current frame. Sits between the per-pixel XOR/difference stage and the match-decision logic, producing one window SAD per accepted column once the window is full.

## Interface
- NDATA_IN, 100: bits per input column (≥2)
- WIN, 8: window length in columns (≥1, need not be a power of 2)
- IDXW, 16: width of in-frame column index
- Derived: LVL = clog2(NDATA_IN); CW = clog2(NDATA_IN+1); SW = clog2(NDATA_IN*WIN+1); LAT = LVL+1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  din holds a valid column this cycle
- din  in  NDATA_IN  difference bits of one column
- frame_start  in  1  qualified by din_valid; this column is column 0 of a new frame
- col_valid  out  1  col_count valid
- col_count  out  CW  popcount of one column
- dout_valid  out  1  dout valid (window full)
- dout  out  SW  sum of col_count over the newest WIN columns of the frame
- min_sad  out  SW  smallest dout this frame (macro-dependent)
- min_idx  out  IDXW  index of newest column of that window (macro-dependent)

## Operation
- Tree: din zero-padded to 2^LVL bits; level k adds pairs from level k-1; every level registered; level k result width k+1; final level truncated to CW bits (lossless).
- din_valid and frame_start travel through a LVL-deep shift register alongside the data; no back-pressure, one column per cycle accepted.
- Window stage, on an emerging valid column c:
  - frame_start: all WIN buffer entries cleared, entry[0] := c, wr_ptr := 1 (mod WIN), sum := c, fill := 1, col_idx := 0.
  - else: sum := sum + c − buf[wr_ptr]; buf[wr_ptr] := c; wr_ptr increments, wraps WIN−1 → 0; fill saturates at WIN; col_idx increments, wraps at 2^IDXW.
  - dout := new sum; dout_valid := 1 only when updated fill == WIN.
- Columns before the first frame_start after reset are processed as if a frame started at reset (buffer zero, fill counting from 0).
- Invalid cycles (bubbles): no state change; col_valid/dout_valid low; col_count/dout hold last value.
- WIN = 1: dout = col_count, dout_valid with every col_valid.
- Sum never exceeds NDATA_IN*WIN; no overflow handling needed.

## Timing
- din at edge t → col_count/col_valid at t+LVL → dout/dout_valid at t+LAT (LAT = 8 for defaults).
- First dout_valid for a frame: WIN−1 valid columns after the frame_start column, i.e. on its WINth column.
- col_valid and dout_valid are single-cycle pulses per column; back-to-back valid columns give back-to-back pulses.
- Reset: all pipeline registers, valids, buffer, sum, fill, pointers, col_idx cleared; all outputs 0 on the cycle after rst is sampled high; in-flight columns discarded; min_sad resets to all-ones when the macro is defined.
- frame_start in mid-pipeline takes effect exactly when its column reaches the window stage; columns ahead of it still update the old frame.

## Configuration
- SADWIN_MIN_TRACK_EN defined: min_sad/min_idx tracked. On a frame_start column, min_sad := all-ones and min_idx := 0 before that column is evaluated. On each dout_valid, if dout < min_sad (strict; ties keep the earlier window), then min_sad := dout and min_idx := col_idx; the update is visible on the cycle after dout_valid.
- Undefined: no tracking registers; min_sad and min_idx tied to 0.

## Test plan
- Reset, then 10 back-to-back all-ones columns with frame_start on the first: col_count = 100 from t+7; dout_valid first on the 8th column, at t+8+7; dout = 800 for columns 8–10.
- Single-bit columns (bit 0 only, then bit 99 only, then 0x0): col_count = 1, 1, 0; checks padding and tree ends.
- Counts 1..12 fed with random bubbles between valid columns: dout = 36, 44, 52, 60, 68 on the valid columns 8–12; no change or pulses during bubbles.
- frame_start on column 9 of a running stream: dout_valid low for the next 7 valid columns, high on the 8th with the sum of only the new-frame columns.
- rst asserted for 1 cycle while 5 columns are in flight: all outputs 0 the next cycle; no col_valid/dout_valid from the dropped columns.
- With SADWIN_MIN_TRACK_EN, window sums 40, 30, 30, 50: min_sad = 30, min_idx = index of the first 30 window; after a new frame_start, min_sad = all-ones until the new frame's first dout_valid.
